pp_icache_nway: RTL and testbench

PP_ICACHE_NWAY -- requirements
Module: pp_icache_nway

---
 rtl/pp_icache_nway.sv | 205 ++++++++++++++++++++
 tb/tb_pp_icache_nway.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_icache_nway.sv
// N-way set-associative instruction cache with tree-PLRU replacement and multi-lane fetch.
// One request is held in S2; a miss refills a whole 256-bit line from the downstream port.
module pp_icache_nway #(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned SETS        = 16,
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                ufp_addr,
  input  logic [3:0]                 ufp_rmask,
  input  logic                       ufp_flush,
  input  logic                       ufp_inval,
  output logic                       ufp_ready,
  output logic                       ufp_resp,
  output logic [FETCH_WIDTH-1:0]     ufp_rvalid,
  output logic [32*FETCH_WIDTH-1:0]  ufp_rdata,
  output logic [31:0]                dfp_addr,
  output logic                       dfp_read,
  input  logic [255:0]               dfp_rdata,
  input  logic                       dfp_resp,
  output logic [31:0]                perf_hits,
  output logic [31:0]                perf_misses
);

  localparam int unsigned SW    = $clog2(SETS);
  localparam int unsigned NW    = $clog2(WAYS);
  localparam int unsigned TAG_W = 27 - SW;

  typedef enum logic [1:0] {RUN, ALLOC, DRAIN} state_t;

  state_t      state;
  logic        s2_valid;
  logic [31:0] s2_addr;
  logic [3:0]  s2_rmask;
  logic        inval_pend;

  logic [255:0]     data_arr  [SETS][WAYS];
  logic [TAG_W-1:0] tag_arr   [SETS][WAYS];
  logic [WAYS-1:0]  valid_arr [SETS];
  // Tree bits live in [WAYS-2:0]; the top bit pads the vector so node indices stay NW wide.
  logic [WAYS-1:0]  plru_arr  [SETS];

  logic [TAG_W-1:0] s2_tag;
  logic [SW-1:0]    s2_idx;
  logic [2:0]       s2_word;
  logic             hit, found_inv, resp_hit, resp_fill, accept, install;
  logic [NW-1:0]    hit_way, victim;
  logic [255:0]     line_sel;
  logic             unused_addr;

  assign s2_tag      = s2_addr[31:32-TAG_W];
  assign s2_idx      = s2_addr[4+SW:5];
  assign s2_word     = s2_addr[4:2];
  assign unused_addr = ^s2_addr[1:0];

  // Walk from the root; a 0 bit means the left subtree is least recently used.
  function automatic logic [NW-1:0] plru_victim(input logic [WAYS-1:0] p);
    logic [NW-1:0] node, way;
    node = '0;
    way  = '0;
    for (int l = 0; l < NW; l++) begin
      way  = NW'({way, p[node]});
      node = NW'(2 * 32'(node) + 32'd1 + 32'(p[node]));
    end
    return way;
  endfunction

  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] p,
                                                 input logic [NW-1:0]   w);
    logic [WAYS-1:0] q;
    logic [NW-1:0]   node, rem;
    logic            b;
    q    = p;
    node = '0;
    rem  = w;
    for (int l = 0; l < NW; l++) begin
      b       = rem[NW-1];
      q[node] = ~b;
      node    = NW'(2 * 32'(node) + 32'd1 + 32'(b));
      rem     = rem << 1;
    end
    return q;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_arr[s2_idx][w] && tag_arr[s2_idx][w] == s2_tag) begin
        hit     = 1'b1;
        hit_way = NW'(w);
      end
    end
  end

  always_comb begin
    found_inv = 1'b0;
    victim    = plru_victim(plru_arr[s2_idx]);
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_arr[s2_idx][w]) begin
        found_inv = 1'b1;
        victim    = NW'(w);
      end
    end
  end

  assign line_sel  = (state == RUN) ? data_arr[s2_idx][hit_way] : dfp_rdata;
  assign resp_hit  = (state == RUN) && s2_valid && hit && !ufp_flush;
  assign resp_fill = (state == ALLOC) && dfp_resp && !ufp_flush;
  assign ufp_resp  = resp_hit || resp_fill;
  assign install   = (state != RUN) && dfp_resp;

  assign dfp_read  = (state != RUN);
  assign dfp_addr  = dfp_read ? {s2_addr[31:5], 5'b0} : 32'h0;
  assign ufp_ready = !rst && (state == RUN) && !inval_pend && !ufp_flush && !ufp_inval &&
                     (!s2_valid || hit);
  assign accept    = ufp_ready && (ufp_rmask != 4'h0);

  always_comb begin
    logic [31:0] word_v;
    int unsigned pos;
    word_v     = '0;
    pos        = 0;
    ufp_rvalid = '0;
    ufp_rdata  = '0;
    if (ufp_resp) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        pos = 32'(s2_word) + 32'(k);
        if (pos <= 7) begin
          word_v = line_sel[pos*32 +: 32];
          if (k == 0) begin
            for (int b = 0; b < 4; b++) begin
              if (!s2_rmask[b]) word_v[8*b +: 8] = 8'h00;
            end
          end
          ufp_rvalid[k]        = 1'b1;
          ufp_rdata[32*k +: 32] = word_v;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      s2_valid    <= 1'b0;
      s2_addr     <= '0;
      s2_rmask    <= '0;
      inval_pend  <= 1'b0;
      perf_hits   <= '0;
      perf_misses <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (ufp_inval || inval_pend) begin
            for (int s = 0; s < SETS; s++) begin
              valid_arr[s] <= '0;
              plru_arr[s]  <= '0;
            end
            inval_pend <= 1'b0;
          end else if (resp_hit) begin
            plru_arr[s2_idx] <= plru_touch(plru_arr[s2_idx], hit_way);
          end
          if (resp_hit && perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
          if (s2_valid && !hit && !ufp_flush) begin
            state <= ALLOC;
          end else begin
            s2_valid <= accept;
            if (accept) begin
              s2_addr  <= ufp_addr;
              s2_rmask <= ufp_rmask;
            end
          end
        end
        default: begin
          // Invalidation waits until the outstanding refill has been installed.
          if (ufp_inval) inval_pend <= 1'b1;
          if (dfp_resp) begin
            valid_arr[s2_idx][victim] <= 1'b1;
            plru_arr[s2_idx]          <= plru_touch(plru_arr[s2_idx], victim);
            state                     <= RUN;
            s2_valid                  <= 1'b0;
            if (resp_fill && perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
          end else if (state == ALLOC && ufp_flush) begin
            state    <= DRAIN;
            s2_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      data_arr[s2_idx][victim] <= dfp_rdata;
      tag_arr[s2_idx][victim]  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_pp_icache_nway.sv
// Directed bench for pp_icache_nway: refill, hits, line end, eviction, flush, invalidate, reset.
module tb_pp_icache_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic         ufp_flush, ufp_inval, ufp_ready, ufp_resp;
  logic [1:0]   ufp_rvalid;
  logic [63:0]  ufp_rdata;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  perf_hits, perf_misses;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pp_icache_nway #(.WAYS(4), .SETS(16), .FETCH_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
    .ufp_flush(ufp_flush), .ufp_inval(ufp_inval), .ufp_ready(ufp_ready),
    .ufp_resp(ufp_resp), .ufp_rvalid(ufp_rvalid), .ufp_rdata(ufp_rdata),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ufp_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_dfp_read();
    int n;
    n = 0;
    while (!dfp_read && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  // Issue a request, let it miss and supply the refill; returns what was observed.
  task automatic miss_txn(input logic [31:0] a, input logic [3:0] m, input logic [255:0] line,
                          output logic s2resp, output logic rd, output logic [31:0] daddr,
                          output logic resp, output logic [1:0] rv, output logic [63:0] rdat);
    @(negedge clk); ufp_addr = a; ufp_rmask = m; #1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; #1;
    s2resp = ufp_resp;
    wait_dfp_read();
    rd = dfp_read; daddr = dfp_addr;
    @(negedge clk); dfp_rdata = line; dfp_resp = 1'b1; #1;
    resp = ufp_resp; rv = ufp_rvalid; rdat = ufp_rdata;
    @(posedge clk); #1 dfp_resp = 1'b0;
  endtask

  task automatic hit_txn(input logic [31:0] a, input logic [3:0] m,
                         output logic resp, output logic [1:0] rv, output logic [63:0] rdat);
    @(negedge clk); ufp_addr = a; ufp_rmask = m; #1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; #1;
    resp = ufp_resp; rv = ufp_rvalid; rdat = ufp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ufp_addr = 32'h104; ufp_rmask = 4'hF; ufp_flush = 1'b0; ufp_inval = 1'b0;
    dfp_rdata = '0; dfp_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (ufp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ufp_ready); end
    n_tests++; if (ufp_resp !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0", ufp_resp); end
    n_tests++; if ({ufp_rvalid, ufp_rdata} !== 66'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0", ufp_rvalid, ufp_rdata); end
    n_tests++; if ({dfp_read, dfp_addr} !== 33'h0) begin n_fail++; $display("FAIL rst_dfp: got %b/%h want 0", dfp_read, dfp_addr); end
    @(negedge clk); rst = 1'b0; ufp_rmask = 4'h0; #1;
    n_tests++; if (ufp_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", ufp_ready); end
    n_tests++; if ({perf_hits, perf_misses} !== 64'h0) begin n_fail++; $display("FAIL rst_counters: got %h/%h want 0", perf_hits, perf_misses); end
  endtask

  task automatic test_cold_miss();
    logic s2r, rd, resp;
    logic [31:0] da;
    logic [1:0] rv;
    logic [63:0] rdat;
    logic [255:0] line;
    line = mkline(32'hC0DE_0000);
    line[63:32] = 32'hDEAD_BEEF;
    line[95:64] = 32'h1234_5678;
    miss_txn(32'h104, 4'hF, line, s2r, rd, da, resp, rv, rdat);
    n_tests++; if (s2r !== 1'b0) begin n_fail++; $display("FAIL cold_s2_noresp: got %b want 0", s2r); end
    n_tests++; if (rd !== 1'b1) begin n_fail++; $display("FAIL cold_dfp_read: got %b want 1", rd); end
    n_tests++; if (da !== 32'h100) begin n_fail++; $display("FAIL cold_dfp_addr: got %h want 00000100", da); end
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL cold_resp: got %b want 1", resp); end
    n_tests++; if (rv !== 2'b11) begin n_fail++; $display("FAIL cold_rvalid: got %b want 11", rv); end
    n_tests++; if (rdat !== 64'h12345678_DEADBEEF) begin n_fail++; $display("FAIL cold_rdata: got %h want 12345678deadbeef", rdat); end
    hit_txn(32'h104, 4'hF, resp, rv, rdat);
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL rehit_resp: got %b want 1", resp); end
    n_tests++; if (rdat !== 64'h12345678_DEADBEEF) begin n_fail++; $display("FAIL rehit_rdata: got %h want 12345678deadbeef", rdat); end
    n_tests++; if ({perf_hits, perf_misses} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL cold_counters: got %0d/%0d want 1/1", perf_hits, perf_misses); end
  endtask

  task automatic test_line_end();
    logic resp;
    logic [1:0] rv;
    logic [63:0] rdat;
    hit_txn(32'h11C, 4'b0011, resp, rv, rdat);
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL lineend_resp: got %b want 1", resp); end
    n_tests++; if (rv !== 2'b01) begin n_fail++; $display("FAIL lineend_rvalid: got %b want 01", rv); end
    n_tests++; if (rdat !== 64'h0000_0000_0000_0007) begin n_fail++; $display("FAIL lineend_rdata: got %h want 0000000000000007", rdat); end
  endtask

  task automatic test_back_to_back();
    logic r1, r2, rdy;
    logic [63:0] d1, d2;
    logic [1:0] v2;
    @(negedge clk); ufp_addr = 32'h104; ufp_rmask = 4'hF; #1;
    @(posedge clk);
    @(negedge clk); ufp_addr = 32'h108; ufp_rmask = 4'b0100; #1;
    r1 = ufp_resp; d1 = ufp_rdata; rdy = ufp_ready;
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; #1;
    r2 = ufp_resp; d2 = ufp_rdata; v2 = ufp_rvalid;
    @(posedge clk); #1;
    n_tests++; if ({r1, rdy} !== 2'b11) begin n_fail++; $display("FAIL b2b_first_resp_ready: got %b want 11", {r1, rdy}); end
    n_tests++; if (d1 !== 64'h12345678_DEADBEEF) begin n_fail++; $display("FAIL b2b_first_rdata: got %h want 12345678deadbeef", d1); end
    n_tests++; if ({r2, v2} !== 3'b111) begin n_fail++; $display("FAIL b2b_second_resp: got %b want 111", {r2, v2}); end
    n_tests++; if (d2 !== 64'hC0DE0003_00340000) begin n_fail++; $display("FAIL b2b_second_rdata: got %h want c0de000300340000", d2); end
    n_tests++; if (perf_hits !== 32'd4) begin n_fail++; $display("FAIL b2b_hits: got %0d want 4", perf_hits); end
  endtask

  task automatic test_flush_hit();
    logic r;
    logic [65:0] o;
    @(negedge clk); ufp_addr = 32'h104; ufp_rmask = 4'hF; #1;
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; ufp_flush = 1'b1; #1;
    o = {ufp_resp, ufp_rvalid, ufp_rdata[62:0]};
    r = ufp_resp;
    @(posedge clk); #1 ufp_flush = 1'b0;
    n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL flush_kill_resp: got %b want 0", r); end
    n_tests++; if (o !== 66'h0) begin n_fail++; $display("FAIL flush_kill_data: got %h want 0", o); end
    @(negedge clk); #1;
    n_tests++; if ({ufp_resp, ufp_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_s2_cleared: got %b want 01", {ufp_resp, ufp_ready}); end
    n_tests++; if (perf_hits !== 32'd4) begin n_fail++; $display("FAIL flush_hits: got %0d want 4", perf_hits); end
  endtask

  task automatic test_eviction();
    logic s2r, rd, resp;
    logic [31:0] da;
    logic [1:0] rv;
    logic [63:0] rdat;
    for (int i = 0; i < 5; i++) begin
      miss_txn(32'(i) * 32'h200, 4'hF, mkline(32'h1000_0000 * 32'(i + 1)), s2r, rd, da, resp, rv, rdat);
      n_tests++; if ({s2r, rd, resp} !== 3'b011) begin n_fail++; $display("FAIL fill_%0d_miss: got %b want 011", i, {s2r, rd, resp}); end
      n_tests++; if (rdat[31:0] !== 32'h1000_0000 * 32'(i + 1)) begin n_fail++; $display("FAIL fill_%0d_rdata: got %h want %h", i, rdat[31:0], 32'h1000_0000 * 32'(i + 1)); end
    end
    miss_txn(32'h000, 4'hF, mkline(32'h1100_0000), s2r, rd, da, resp, rv, rdat);
    n_tests++; if ({s2r, rd} !== 2'b01) begin n_fail++; $display("FAIL evicted_way0_misses: got %b want 01", {s2r, rd}); end
    hit_txn(32'h200, 4'hF, resp, rv, rdat);
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL way1_still_hits: got %b want 1", resp); end
    n_tests++; if (rdat !== 64'h20000001_20000000) begin n_fail++; $display("FAIL way1_rdata: got %h want 2000000120000000", rdat); end
    n_tests++; if (perf_misses !== 32'd7) begin n_fail++; $display("FAIL evict_misses: got %0d want 7", perf_misses); end
  endtask

  task automatic test_flush_alloc();
    logic r0, r1, r2, resp;
    logic [32:0] held;
    logic [1:0] rv;
    logic [63:0] rdat;
    @(negedge clk); ufp_addr = 32'h300; ufp_rmask = 4'hF; #1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; #1;
    wait_dfp_read();
    ufp_flush = 1'b1; #1;
    r0 = ufp_resp;
    @(negedge clk); ufp_flush = 1'b0; #1;
    held = {dfp_read, dfp_addr}; r1 = ufp_resp;
    @(negedge clk); dfp_rdata = mkline(32'h3000_0000); dfp_resp = 1'b1; #1;
    r2 = ufp_resp;
    @(posedge clk); #1 dfp_resp = 1'b0;
    n_tests++; if ({r0, r1, r2} !== 3'b000) begin n_fail++; $display("FAIL drain_no_resp: got %b want 000", {r0, r1, r2}); end
    n_tests++; if (held !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL drain_dfp_held: got %h want 100000300", held); end
    hit_txn(32'h300, 4'hF, resp, rv, rdat);
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL drained_line_hits: got %b want 1", resp); end
    n_tests++; if (rdat !== 64'h30000001_30000000) begin n_fail++; $display("FAIL drained_rdata: got %h want 3000000130000000", rdat); end
    n_tests++; if (perf_misses !== 32'd7) begin n_fail++; $display("FAIL drain_not_counted: got %0d want 7", perf_misses); end
  endtask

  task automatic test_inval_run();
    logic r, s2r, rd, resp;
    logic [31:0] da;
    logic [1:0] rv;
    logic [63:0] rdat;
    @(negedge clk); ufp_addr = 32'h200; ufp_rmask = 4'hF; #1;
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; ufp_inval = 1'b1; #1;
    r = ufp_resp;
    @(posedge clk); #1 ufp_inval = 1'b0;
    n_tests++; if (r !== 1'b1) begin n_fail++; $display("FAIL inval_hit_responds: got %b want 1", r); end
    miss_txn(32'h200, 4'hF, mkline(32'h2200_0000), s2r, rd, da, resp, rv, rdat);
    n_tests++; if ({s2r, rd} !== 2'b01) begin n_fail++; $display("FAIL inval_run_cleared: got %b want 01", {s2r, rd}); end
    n_tests++; if ({perf_hits, perf_misses} !== {32'd7, 32'd8}) begin n_fail++; $display("FAIL inval_run_counters: got %0d/%0d want 7/8", perf_hits, perf_misses); end
  endtask

  task automatic test_inval_alloc();
    logic r, s2r, rd, resp;
    logic [31:0] da;
    logic [1:0] rv;
    logic [63:0] rdat;
    @(negedge clk); ufp_addr = 32'h500; ufp_rmask = 4'hF; #1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; #1;
    wait_dfp_read();
    ufp_inval = 1'b1;
    @(negedge clk); ufp_inval = 1'b0; dfp_rdata = mkline(32'h5500_0000); dfp_resp = 1'b1; #1;
    r = ufp_resp; rdat = ufp_rdata;
    @(posedge clk); #1 dfp_resp = 1'b0;
    n_tests++; if (r !== 1'b1) begin n_fail++; $display("FAIL inval_refill_resp: got %b want 1", r); end
    n_tests++; if (rdat !== 64'h55000001_55000000) begin n_fail++; $display("FAIL inval_refill_rdata: got %h want 5500000155000000", rdat); end
    miss_txn(32'h500, 4'hF, mkline(32'h5600_0000), s2r, rd, da, resp, rv, rdat);
    n_tests++; if ({s2r, rd} !== 2'b01) begin n_fail++; $display("FAIL inval_refilled_gone: got %b want 01", {s2r, rd}); end
    n_tests++; if (perf_misses !== 32'd10) begin n_fail++; $display("FAIL inval_misses: got %0d want 10", perf_misses); end
  endtask

  task automatic test_async_reset();
    logic r, rd;
    logic [1:0] rv;
    logic [63:0] rdat;
    @(negedge clk); ufp_addr = 32'h700; ufp_rmask = 4'hF; #1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); ufp_rmask = 4'h0; #1;
    wait_dfp_read();
    rd = dfp_read;
    n_tests++; if (rd !== 1'b1) begin n_fail++; $display("FAIL areset_pre_read: got %b want 1", rd); end
    #2 rst = 1'b1; #1;
    n_tests++; if ({dfp_read, dfp_addr, ufp_ready} !== 34'h0) begin n_fail++; $display("FAIL areset_drop: got %b/%h/%b want 0", dfp_read, dfp_addr, ufp_ready); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); dfp_rdata = mkline(32'h7000_0000); dfp_resp = 1'b1; #1;
    r = ufp_resp;
    @(posedge clk); #1 dfp_resp = 1'b0;
    n_tests++; if ({r, dfp_read} !== 2'b00) begin n_fail++; $display("FAIL late_resp_ignored: got %b want 00", {r, dfp_read}); end
    n_tests++; if ({perf_hits, perf_misses} !== 64'h0) begin n_fail++; $display("FAIL areset_counters: got %0d/%0d want 0/0", perf_hits, perf_misses); end
    hit_txn(32'h700, 4'hF, r, rv, rdat);
    n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL late_resp_no_install: got %b want 0", r); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_end();
    test_back_to_back();
    test_flush_hit();
    test_eviction();
    test_flush_alloc();
    test_inval_run();
    test_inval_alloc();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
